// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM burst master: FSM state encoding and
// default address/data widths.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram_rd_fifo2.sv
// Two-entry read-data FIFO between the RAM read port and the read consumer.
// Push is ignored when full, pop is ignored when empty.
module ram_rd_fifo2
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so stale entries never leak out.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and count
  // makes every entry invalid, and the output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst master for a single-port synchronous RAM with 1-cycle read latency:
// accepts write/read burst commands and sequences RAM accesses per beat.
module ram_burst_master
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wd_valid,
  input  logic [DATA_W-1:0] wd_data,
  output logic              wd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] last_beat;
  logic [ADDR_W-1:0] beat;
  logic [ADDR_W-1:0] beat_addr;
  logic              in_flight;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_beat;
  logic              rd_issue;

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign beat_addr = start_addr + beat;
  assign wr_beat   = (state == WRITE) && wd_valid;

  // Occupancy + in-flight < 2, expressed with the FIFO flags.
  assign rd_issue  = (state == READ) && (fifo_empty || (!fifo_full && !in_flight));

  assign cmd_ready = (state == IDLE);
  assign wd_ready  = wr_beat;
  assign rd_valid  = !fifo_empty;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (wr_beat) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = beat_addr;
      ram_din  = wd_data;
    end else if (rd_issue) begin
      ram_en   = 1'b1;
      ram_addr = beat_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_addr <= '0;
      last_beat  <= '0;
      beat       <= '0;
      in_flight  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= rd_issue;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            start_addr <= cmd_addr;
            last_beat  <= cmd_len;
            beat       <= '0;
            state      <= cmd_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wd_valid) begin
            if (beat == last_beat) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            if (beat == last_beat) state <= DRAIN;
            else                   beat  <= beat + 1'b1;
          end
        end
        DRAIN: begin
          if (!in_flight && fifo_empty) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data for the read issued last cycle is on ram_dout now.
  ram_rd_fifo2 #(.DATA_W(DATA_W)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_data (ram_dout),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: table-driven write bursts against a behavioural
// 256x8 RAM, then hand-written read, stall and mid-burst reset sequences.
module tb_ram_burst_master;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wd_valid;
  logic [7:0] wd_data;
  logic       wd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic       done;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;

  ram_burst_master #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_data   (wd_data),
    .wd_ready  (wd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .done      (done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural synchronous RAM, 1-cycle read latency.
  logic [7:0] ram_mem   [256];
  logic [7:0] model_mem [256];

  initial begin
    ram_dout = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = 8'(i) ^ 8'h5A;
      model_mem[i] = 8'(i) ^ 8'h5A;
    end
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_wd_ready"},  wd_ready,  0);
    check({tag, "_rd_valid"},  rd_valid,  0);
    check({tag, "_rd_data"},   rd_data,   0);
    check({tag, "_done"},      done,      0);
    check({tag, "_ram_en"},    ram_en,    0);
    check({tag, "_ram_we"},    ram_we,    0);
    check({tag, "_ram_addr"},  ram_addr,  0);
    check({tag, "_ram_din"},   ram_din,   0);
  endtask

  typedef struct {
    logic       cv;
    logic       cw;
    logic [7:0] ca;
    logic [7:0] cl;
    logic       wv;
    logic [7:0] wd;
    logic       x_cmd_ready;
    logic       x_wd_ready;
    logic       x_en;
    logic [7:0] x_addr;
    logic [7:0] x_din;
    logic       x_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic cv, logic cw, logic [7:0] ca, logic [7:0] cl,
                              logic wv, logic [7:0] wd, logic xr, logic xw, logic xe,
                              logic [7:0] xa, logic [7:0] xd, logic xdone);
    vec_t v;
    v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd;
    v.x_cmd_ready = xr; v.x_wd_ready = xw; v.x_en = xe;
    v.x_addr = xa; v.x_din = xd; v.x_done = xdone;
    return v;
  endfunction

  function automatic void add_cmd(logic [7:0] a, logic [7:0] l);
    vecs.push_back(mk(1, 1, a, l, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0));
  endfunction

  function automatic void add_beat(logic [7:0] a, logic [7:0] d);
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, d, 0, 1, 1, a, d, 0));
  endfunction

  function automatic void add_gap(logic [7:0] d);
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, d, 0, 0, 0, 8'h00, 8'h00, 0));
  endfunction

  function automatic void add_idle(logic xdone, logic wv);
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, wv, 8'h55, 1, 0, 0, 8'h00, 8'h00, xdone));
  endfunction

  // Read burst with rd_ready held low for the first 'stall' cycles after accept.
  task automatic read_burst(input logic [7:0] addr, input logic [7:0] len,
                            input int stall, input string tag);
    int issued = 0;
    int got    = 0;
    int cyc    = 0;
    bit seen   = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = addr; cmd_len = len;
    rd_ready  = (stall == 0);
    #1;
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rd_ready  = (cyc >= stall);
      #1;
      if (ram_en) begin
        check({tag, "_rd_we"},   ram_we,   0);
        check({tag, "_rd_addr"}, ram_addr, 8'(addr + 8'(issued)));
        issued++;
      end
      if (rd_valid && rd_ready) begin
        check({tag, "_rd_data"}, rd_data, model_mem[8'(addr + 8'(got))]);
        got++;
      end
      if (stall > 0 && cyc == stall - 1) begin
        check({tag, "_stall_issued"}, issued, 2);
        check({tag, "_stall_rd_valid"}, rd_valid, 1);
      end
      if (done) begin
        seen = 1;
        check({tag, "_done_cmd_ready"}, cmd_ready, 1);
      end
      cyc++;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_issued"},    issued, int'(len) + 1);
    check({tag, "_beats"},     got,    int'(len) + 1);
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    check({tag, "_done_pulse_end"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h33; cmd_len = 8'h01;
    wd_valid = 1'b1; wd_data = 8'h77; rd_ready = 1'b1;

    // Reset state, with inputs active to show nothing is accepted.
    #1;
    check_idle_outputs("reset_early");
    @(negedge clk);
    #1;
    check_idle_outputs("reset_held");
    @(negedge clk);
    cmd_valid = 1'b0; wd_valid = 1'b0; rd_ready = 1'b0; rst_n = 1'b1;
    #1;
    check_idle_outputs("reset_release");

    // Write bursts: back-to-back, outside-WRITE data, wrap-around, gaps, LEN=0.
    add_cmd(8'h10, 8'd3);
    for (int i = 0; i < 4; i++) add_beat(8'(8'h10 + i), 8'(8'hA0 + i));
    add_idle(1, 0);
    add_idle(0, 1);
    add_cmd(8'hFE, 8'd3);
    for (int i = 0; i < 4; i++) add_beat(8'(8'hFE + i), 8'(8'hB0 + i));
    add_idle(1, 0);
    add_cmd(8'h40, 8'd5);
    for (int i = 0; i < 6; i++) begin
      add_beat(8'(8'h40 + i), 8'(8'hC0 + i));
      if (i < 5) add_gap(8'hEE);
    end
    add_idle(1, 0);
    add_cmd(8'h80, 8'd0);
    add_beat(8'h80, 8'hD0);
    add_idle(1, 0);
    add_idle(0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      cmd_valid = vecs[k].cv; cmd_wr = vecs[k].cw; cmd_addr = vecs[k].ca; cmd_len = vecs[k].cl;
      wd_valid  = vecs[k].wv; wd_data = vecs[k].wd;
      #1;
      check($sformatf("vec%0d_cmd_ready", k), cmd_ready, vecs[k].x_cmd_ready);
      check($sformatf("vec%0d_wd_ready", k),  wd_ready,  vecs[k].x_wd_ready);
      check($sformatf("vec%0d_ram_en", k),    ram_en,    vecs[k].x_en);
      check($sformatf("vec%0d_ram_we", k),    ram_we,    vecs[k].x_en);
      check($sformatf("vec%0d_ram_addr", k),  ram_addr,  vecs[k].x_addr);
      check($sformatf("vec%0d_ram_din", k),   ram_din,   vecs[k].x_din);
      check($sformatf("vec%0d_done", k),      done,      vecs[k].x_done);
      check($sformatf("vec%0d_rd_valid", k),  rd_valid,  0);
      if (vecs[k].x_en) model_mem[vecs[k].x_addr] = vecs[k].x_din;
    end
    cmd_valid = 1'b0; wd_valid = 1'b0;

    // Reads: plain burst, stalled consumer, then LEN=0.
    read_burst(8'h10, 8'd3, 0, "rd_basic");
    read_burst(8'h40, 8'd7, 10, "rd_stall");
    read_burst(8'hFE, 8'd3, 0, "rd_wrap");
    read_burst(8'h80, 8'd0, 0, "rd_len0");

    // Reset asserted while the third read beat is available.
    begin
      int  got      = 0;
      int  cyc      = 0;
      bit  at_third = 0;
      bit  early    = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'hFE; cmd_len = 8'd7; rd_ready = 1'b1;
      while (!at_third && cyc < 50) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        if (done) early = 1;
        if (rd_valid) begin
          if (got == 2) at_third = 1;
          else          got++;
        end
        cyc++;
      end
      check("abort_third_beat_reached", at_third, 1);
      check("abort_no_early_done", early, 0);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("abort_now");
      @(negedge clk);
      #1;
      check_idle_outputs("abort_held");
      rst_n = 1'b1;
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        check($sformatf("abort_after_done%0d", i), done, 0);
        check($sformatf("abort_after_rd_valid%0d", i), rd_valid, 0);
      end
    end
    read_burst(8'h10, 8'd3, 0, "rd_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
